piso_shift_scheduler: RTL and testbench

- Two-requester round-robin scheduler for a shared parallel-in/serial-out shift datapath.
- Grants one requester at a time and accepts its BITS-wide word via a valid/ready handshake.
- Serialises the accepted word MSB-first on a single serial lane with frame markers; the downstream sink can apply backpressure.
- Sits between word-level producers and any serial link or bit-level consumer in the design.

---
 rtl/piso_shift_scheduler_if.sv | 33 +++
 rtl/piso_shift_scheduler.sv | 101 ++++++++++
 tb/tb_piso_shift_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/piso_shift_scheduler_if.sv
// piso_shift_scheduler_if
//   Bundles the two word-level requester handshakes and the serial output
//   lane of piso_shift_scheduler.
//   master : producer/sink side (drives req*_valid, req*_data, ser_ready)
//   slave  : scheduler side (drives req*_ready, ser_*, busy)
// Parameter BITS: word width, 2..32.
interface piso_shift_scheduler_if #(parameter int BITS = 4);
  logic            req0_valid;
  logic [BITS-1:0] req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [BITS-1:0] req1_data;
  logic            req1_ready;
  logic            ser_ready;
  logic            ser_out;
  logic            ser_valid;
  logic            ser_first;
  logic            ser_last;
  logic            ser_src;
  logic            busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, ser_ready,
    input  req0_ready, req1_ready, ser_out, ser_valid, ser_first,
           ser_last, ser_src, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, ser_ready,
    output req0_ready, req1_ready, ser_out, ser_valid, ser_first,
           ser_last, ser_src, busy
  );
endinterface

// File: rtl/piso_shift_scheduler.sv
// piso_shift_scheduler
//   Two-requester round-robin scheduler feeding a shared PISO shifter.
//   A granted word is accepted with valid/ready, then shifted out MSB-first
//   with ser_first/ser_last frame markers; ser_ready stalls the lane.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - piso_shift_scheduler_if.slave (requester handshakes, serial lane)
// Build option:
//   PISO_SCHED_BTB_EN - when defined, the next word may be accepted in the
//   same cycle the previous LSB transfers, giving gapless back-to-back words.
//
// state | meaning
// ------+------------------------------------------------------
// IDLE  | no word in flight; grant logic active
// SHIFT | word in shreg_q being serialised, bitcnt_q bits left-1
module piso_shift_scheduler #(
  parameter int BITS = 4
) (
  input logic                  CLK,
  input logic                  RST,
  piso_shift_scheduler_if.slave bus
);
  localparam int CW = $clog2(BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(BITS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]   bitcnt_q, bitcnt_d;
  logic            src_q, src_d;
  logic            rr_ptr_q, rr_ptr_d;
  // Low for the first cycle after reset release so no ready can fire then.
  logic            init_q;

  logic in_shift, xfer, grant_en, gnt_idx, rdy0, rdy1, accept;

  always_comb begin
    in_shift = (state_q == SHIFT);
    xfer     = in_shift && bus.ser_ready;
`ifdef PISO_SCHED_BTB_EN
    grant_en = init_q && (!in_shift || (xfer && (bitcnt_q == '0)));
`else
    grant_en = init_q && !in_shift;
`endif
    // Contention goes to rr_ptr; otherwise whichever requester is valid.
    gnt_idx  = (bus.req0_valid && bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
    rdy0     = grant_en && bus.req0_valid && !gnt_idx;
    rdy1     = grant_en && bus.req1_valid && gnt_idx;
    accept   = rdy0 || rdy1;

    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    src_d    = src_q;
    rr_ptr_d = rr_ptr_q;

    if (xfer) begin
      shreg_d  = {shreg_q[BITS-2:0], 1'b0};
      bitcnt_d = bitcnt_q - CW'(1);
      if (bitcnt_q == '0) state_d = IDLE;
    end

    // A load overrides the final shift when back-to-back is enabled.
    if (accept) begin
      shreg_d  = gnt_idx ? bus.req1_data : bus.req0_data;
      src_d    = gnt_idx;
      bitcnt_d = CNT_MAX;
      rr_ptr_d = ~gnt_idx;
      state_d  = SHIFT;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      src_q    <= 1'b0;
      rr_ptr_q <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
      init_q   <= 1'b1;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.ser_valid  = in_shift;
  assign bus.busy       = in_shift;
  assign bus.ser_out    = in_shift && shreg_q[BITS-1];
  assign bus.ser_first  = in_shift && (bitcnt_q == CNT_MAX);
  assign bus.ser_last   = in_shift && (bitcnt_q == '0);
  assign bus.ser_src    = src_q;
endmodule

// File: tb/tb_piso_shift_scheduler.sv
module tb_piso_shift_scheduler;
  logic CLK;
  logic RST;

  piso_shift_scheduler_if #(.BITS(4)) bus ();

  piso_shift_scheduler #(.BITS(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

`ifdef PISO_SCHED_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // expected/observed packing: {r0, r1, valid, out, first, last, src, busy}
  typedef struct {
    logic       v0;
    logic [3:0] d0;
    logic       v1;
    logic [3:0] d1;
    logic       sr;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [7:0] obs();
    return {bus.req0_ready, bus.req1_ready, bus.ser_valid, bus.ser_out,
            bus.ser_first, bus.ser_last, bus.ser_src, bus.busy};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got r0r1 v o f l s b=%b, expected %b", name, act, exp);
  endtask

  task automatic add_vec(input logic v0, input logic [3:0] d0, input logic v1,
                         input logic [3:0] d1, input logic sr, input logic [7:0] exp,
                         input string name);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.sr = sr; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // One word with ser_ready high: optional idle/accept row, then 4 shift rows.
  // last_rdy is the {r0,r1} expected on the LSB row (back-to-back grants).
  task automatic push_word(input string tag,
                           input logic iv0, input logic [3:0] id0,
                           input logic iv1, input logic [3:0] id1,
                           input logic sv0, input logic [3:0] sd0,
                           input logic sv1, input logic [3:0] sd1,
                           input bit has_idle, input logic [1:0] last_rdy,
                           input logic gnt, input logic src_prev,
                           input logic [3:0] word);
    if (has_idle)
      add_vec(iv0, id0, iv1, id1, 1'b1,
              {!gnt, gnt, 4'b0000, src_prev, 1'b0}, {tag, "_accept"});
    for (int i = 0; i < 4; i++) begin
      add_vec(sv0, sd0, sv1, sd1, 1'b1,
              {(i == 3) ? last_rdy : 2'b00, 1'b1, word[3-i],
               (i == 0), (i == 3), gnt, 1'b1},
              $sformatf("%s_bit%0d", tag, i));
    end
  endtask

  task automatic apply(input logic v0, input logic [3:0] d0, input logic v1,
                       input logic [3:0] d1, input logic sr, input logic [7:0] exp,
                       input string name);
    @(negedge CLK);
    bus.req0_valid = v0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_data = d1;
    bus.ser_ready  = sr;
    #1;
    check(name, obs(), exp);
  endtask

  initial begin
    // Round-robin with both requesters held valid; accept order 0,1,0,1.
    push_word("rr0", 1, 4'hA, 1, 4'h5, 1, 4'hA, 1, 4'h5, 1'b1,
              BTB ? 2'b01 : 2'b00, 1'b0, 1'b0, 4'hA);
    push_word("rr1", 1, 4'hA, 1, 4'h5, 1, 4'hA, 1, 4'h5, !BTB,
              BTB ? 2'b10 : 2'b00, 1'b1, 1'b0, 4'h5);
    push_word("rr2", 1, 4'hA, 1, 4'h5, 1, 4'hA, 1, 4'h5, !BTB,
              BTB ? 2'b01 : 2'b00, 1'b0, 1'b1, 4'hA);
    push_word("rr3", 1, 4'hA, 1, 4'h5, 0, 4'hA, 0, 4'h5, !BTB,
              2'b00, 1'b1, 1'b0, 4'h5);
    // Single word from req0; ser_src held at 1 from previous word while idle.
    push_word("single", 1, 4'b1011, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1'b1,
              2'b00, 1'b0, 1'b1, 4'b1011);
    // Backpressure on the second bit of 4'b1100 from req1.
    add_vec(0, 4'h0, 1, 4'b1100, 1, 8'b0100_0000, "bp_accept");
    add_vec(0, 4'h0, 0, 4'h0,    1, 8'b0011_1011, "bp_bit0");
    add_vec(0, 4'h0, 0, 4'h0,    0, 8'b0011_0011, "bp_stall0");
    add_vec(0, 4'h0, 0, 4'h0,    0, 8'b0011_0011, "bp_stall1");
    add_vec(0, 4'h0, 0, 4'h0,    0, 8'b0011_0011, "bp_stall2");
    add_vec(0, 4'h0, 0, 4'h0,    1, 8'b0011_0011, "bp_bit1");
    add_vec(0, 4'h0, 0, 4'h0,    1, 8'b0010_0011, "bp_bit2");
    add_vec(0, 4'h0, 0, 4'h0,    1, 8'b0010_0111, "bp_bit3");
    // Data changes after accept must not reach the lane.
    push_word("stable", 1, 4'hF, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1'b1,
              2'b00, 1'b0, 1'b1, 4'hF);
    add_vec(0, 4'h0, 0, 4'h0, 1, 8'b0000_0000, "idle_after");

    RST = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = 4'hA;
    bus.req1_valid = 1'b1; bus.req1_data = 4'h5;
    bus.ser_ready  = 1'b1;
    @(negedge CLK); @(negedge CLK); #1;
    check("rst_init", obs(), 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_first_cycle", obs(), 8'h00);

    foreach (vecs[i])
      apply(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].sr,
            vecs[i].exp, vecs[i].name);

    // Reset mid-word after two bits of 4'b1011.
    apply(1, 4'b1011, 0, 4'h0, 1, 8'b1000_0000, "mid_accept");
    apply(0, 4'h0,    0, 4'h0, 1, 8'b0011_1001, "mid_bit0");
    apply(0, 4'h0,    0, 4'h0, 1, 8'b0010_0001, "mid_bit1");
    @(negedge CLK);
    bus.req0_valid = 1'b1; bus.req0_data = 4'b1011;
    bus.req1_valid = 1'b1; bus.req1_data = 4'h5;
    RST = 1'b1;
    #1;
    check("mid_rst_async", obs(), 8'h00);
    @(negedge CLK); #1;
    check("mid_rst_held", obs(), 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("mid_rst_release", obs(), 8'h00);
    apply(1, 4'b1011, 1, 4'h5, 1, 8'b1000_0000, "fresh_accept");
    apply(0, 4'h0,    0, 4'h0, 1, 8'b0011_1001, "fresh_first");
    apply(0, 4'h0,    0, 4'h0, 1, 8'b0010_0001, "fresh_bit1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
